// File: rtl/imm_decode_stage.sv
// Registered RV32I immediate-decode stage: decodes each accepted instruction into
// a sign-extended immediate, format code and illegal flag, buffered in a 2-entry skid FIFO.
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter bit B_SCALED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_ins,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [31:0]      ins;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t dec;
  logic [31:0] v32;
  logic push, pop;

  // Every format's sign bit is ins[31]; v32 holds the 32-bit value, widened below.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    dec         = '0;
    v32         = '0;
    dec.ins     = in_ins;
    dec.tag     = in_tag;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (in_ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        v32     = {{20{in_ins[31]}}, in_ins[31:20]};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        v32     = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      end
      OP_BR: begin
        dec.fmt = FMT_B;
        if (B_SCALED)
          v32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
        else
          v32 = {{20{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8]};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        v32     = {in_ins[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        v32     = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
      end
      OP_REG, OP_SYS, OP_FENCE: dec.fmt = FMT_NONE;
      default: begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm       = {XLEN{v32[31]}};
    dec.imm[31:0] = v32;
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_d  = dec;
          state_d = ONE;
        end
        ONE: case ({push, pop})
          2'b10: begin
            tail_d  = dec;
            state_d = FULL;
          end
          2'b01: begin
            head_d  = '0;
            state_d = EMPTY;
          end
          2'b11: head_d = dec;
          default: ;
        endcase
        FULL: if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  // NOTE: the tail slot is plain storage; it is only read once state says it holds data, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;
  assign out_ins     = head_q.ins;
  assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: two configurations (XLEN=32 scaled-B,
// XLEN=64 legacy-B) share stimulus and are checked against a queue-based reference model.
module tb_imm_decode_stage;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_ins, in_tag;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm, a_ins, a_tag;
  logic [2:0]  a_fmt;
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_imm;
  logic [31:0] b_ins, b_tag;
  logic [2:0]  b_fmt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] tag;
  } item_t;
  item_t q[$];
  bit zero_exp;

  imm_decode_stage #(.XLEN(32), .TAG_W(32), .B_SCALED(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ins(in_ins), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_illegal), .out_ins(a_ins), .out_tag(a_tag)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32), .B_SCALED(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ins(in_ins), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_illegal), .out_ins(b_ins), .out_tag(b_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Immediate value computed as a signed integer from the field weights.
  function automatic void ref_decode(input logic [31:0] ins, input bit scaled,
                                     output longint imm, output logic [2:0] fmt,
                                     output logic ill);
    longint s;
    s   = ins[31] ? 64'sd1 : 64'sd0;
    imm = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        fmt = 3'd1;
        imm = longint'(ins[31:20]) - s * 4096;
      end
      7'b0100011: begin
        fmt = 3'd2;
        imm = longint'({ins[31:25], ins[11:7]}) - s * 4096;
      end
      7'b1100011: begin
        fmt = 3'd3;
        if (scaled)
          imm = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2 - s * 4096;
        else
          imm = longint'(ins[7]) * 1024 + longint'(ins[30:25]) * 16
              + longint'(ins[11:8]) - s * 2048;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        imm = longint'(ins[31:12]) * 4096 - s * 64'sd4294967296;
      end
      7'b1101111: begin
        fmt = 3'd5;
        imm = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
            + longint'(ins[30:21]) * 2 - s * 1048576;
      end
      7'b0110011, 7'b1110011, 7'b0001111: ;
      default: begin
        fmt = 3'd7;
        ill = 1'b1;
      end
    endcase
  endfunction

  task automatic check_zero(input string where);
    check({where, " a_imm"}, 64'(a_imm), 64'd0);
    check({where, " a_fmt"}, 64'(a_fmt), 64'd0);
    check({where, " a_illegal"}, 64'(a_illegal), 64'd0);
    check({where, " a_ins"}, 64'(a_ins), 64'd0);
    check({where, " a_tag"}, 64'(a_tag), 64'd0);
    check({where, " b_imm"}, b_imm, 64'd0);
    check({where, " b_fmt"}, 64'(b_fmt), 64'd0);
    check({where, " b_ins_tag"}, {b_ins, b_tag}, 64'd0);
  endtask

  task automatic check_outputs();
    longint     imm;
    logic [2:0] fmt;
    logic       ill;
    int         n;
    n = q.size();
    check("a_out_valid", 64'(a_out_valid), 64'(n > 0));
    check("b_out_valid", 64'(b_out_valid), 64'(n > 0));
    check("a_in_ready", 64'(a_in_ready), 64'(n < 2));
    check("b_in_ready", 64'(b_in_ready), 64'(n < 2));
    if (n > 0) begin
      ref_decode(q[0].ins, 1'b1, imm, fmt, ill);
      check("a_imm", 64'(a_imm), {32'd0, imm[31:0]});
      check("a_fmt", 64'(a_fmt), 64'(fmt));
      check("a_illegal", 64'(a_illegal), 64'(ill));
      check("a_ins", 64'(a_ins), 64'(q[0].ins));
      check("a_tag", 64'(a_tag), 64'(q[0].tag));
      ref_decode(q[0].ins, 1'b0, imm, fmt, ill);
      check("b_imm", b_imm, imm);
      check("b_fmt", 64'(b_fmt), 64'(fmt));
      check("b_illegal", 64'(b_illegal), 64'(ill));
      check("b_ins_tag", {b_ins, b_tag}, {q[0].ins, q[0].tag});
    end else if (zero_exp) begin
      check_zero("empty");
    end
  endtask

  // Drive one cycle from a falling edge, advance the model at the rising edge,
  // and compare at the next falling edge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] tag,
                      input bit ordy, input bit fl);
    bit do_push, do_pop;
    in_valid  = v;
    in_ins    = ins;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    do_push   = v && (q.size() < 2) && !fl;
    do_pop    = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      zero_exp = 1'b1;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{ins: ins, tag: tag});
        zero_exp = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    zero_exp = 1'b1;
    check("rst a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst b_out_valid", 64'(b_out_valid), 64'd0);
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic directed(input logic [31:0] ins, input logic [31:0] exp32,
                          input logic [63:0] exp64, input logic [2:0] fmt, input logic ill);
    step(1'b1, ins, ins, 1'b1, 1'b0);
    check("dir valid", 64'(a_out_valid), 64'd1);
    check("dir a_imm", 64'(a_imm), 64'(exp32));
    check("dir b_imm", b_imm, exp64);
    check("dir fmt", 64'(a_fmt), 64'(fmt));
    check("dir illegal", 64'(a_illegal), 64'(ill));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  localparam int NOPC = 11;
  logic [6:0] opcs [NOPC] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                              7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011,
                              7'b0001111};

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ins    = '0;
    in_tag    = '0;
    zero_exp  = 1'b1;
    #2;
    check("init a_out_valid", 64'(a_out_valid), 64'd0);
    check("init a_in_ready", 64'(a_in_ready), 64'd1);
    check_zero("init");
    @(negedge clk);
    rst_n = 1'b1;

    directed(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    directed(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFE, 3'd3, 1'b0);
    directed(32'h008000EF, 32'h00000008, 64'h0000000000000008, 3'd5, 1'b0);
    directed(32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    directed(32'hFE112C23, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
    directed(32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1);
    directed(32'h002081B3, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0);

    // Stall with three pushes, then release.
    step(1'b1, 32'h00100093, 32'd1, 1'b0, 1'b0);
    check("stall ready1", 64'(a_in_ready), 64'd1);
    step(1'b1, 32'h00200093, 32'd2, 1'b0, 1'b0);
    check("stall ready2", 64'(a_in_ready), 64'd0);
    step(1'b1, 32'h00300093, 32'd3, 1'b0, 1'b0);
    check("stall head", 64'(a_tag), 64'd1);
    step(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0);
    check("rel tag2", 64'(a_tag), 64'd2);
    check("rel ready", 64'(a_in_ready), 64'd1);
    step(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0);
    check("rel tag3", 64'(a_tag), 64'd3);
    check("rel valid3", 64'(a_out_valid), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Flush a full buffer with a concurrent push.
    step(1'b1, 32'h00A00093, 32'd10, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 32'd11, 1'b0, 1'b0);
    step(1'b1, 32'h00C00093, 32'd12, 1'b0, 1'b1);
    check("flush valid", 64'(a_out_valid), 64'd0);
    check("flush ready", 64'(a_in_ready), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Reset mid-stream.
    step(1'b1, 32'h00D00093, 32'd13, 1'b0, 1'b0);
    step(1'b1, 32'h00E00093, 32'd14, 1'b0, 1'b0);
    pulse_reset();
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r   = $urandom;
      opc = ($urandom_range(0, 7) == 0) ? 7'(r[6:0] ^ 7'h55) : opcs[$urandom_range(0, NOPC - 1)];
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step($urandom_range(0, 3) != 0, {r[31:7], opc}, 32'(i + 100),
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
